// File: rtl/debounce_event_scheduler.sv
// Multi-channel switch debouncer with a shared tick prescaler, per-channel
// debounce FSMs and a round-robin drain of rise/fall events onto one
// valid/ready port.

// Per-channel debounce FSM: a new level is accepted after K stable ticks.
module debounce_chan #(
  parameter int K = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sw,
  output logic db,
  output logic ev_set,
  output logic ev_pol
);
  localparam int CW = $clog2(K) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  localparam logic [1:0] S_ZERO = 2'd0;
  localparam logic [1:0] S_W1   = 2'd1;
  localparam logic [1:0] S_ONE  = 2'd2;
  localparam logic [1:0] S_W0   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  // Next-state, qualification count and edge event generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_set  = 1'b0;
    ev_pol  = 1'b0;
    case (state_q)
      S_ZERO: begin
        if (sw) begin
          state_d = S_W1;
          cnt_d   = '0;
        end
      end
      S_W1: begin
        if (!sw) begin
          state_d = S_ZERO;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_ONE;
            ev_set  = 1'b1;
            ev_pol  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_ONE: begin
        if (!sw) begin
          state_d = S_W0;
          cnt_d   = '0;
        end
      end
      S_W0: begin
        if (sw) begin
          state_d = S_ONE;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_ZERO;
            ev_set  = 1'b1;
            ev_pol  = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_ZERO;
    endcase
    // db is decoded from the next state so it moves on the same edge as the event.
    db_d = (state_d == S_ONE) || (state_d == S_W0);
  end

  // State, count and debounced level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_ZERO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign db = db_q;
endmodule

// Top: shared prescaler, channel array, pending flags, arbiter, output slot.
module debounce_event_scheduler #(
  parameter int N   = 4,
  parameter int M   = 1_000_000,
  parameter int K   = 3,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   sw,
  output logic [N-1:0]   db,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [IDW-1:0] ev_chan,
  output logic           ev_rise,
  output logic [N-1:0]   ovr,
  input  logic           ovr_clr
);
  localparam int PW = $clog2(M);
  localparam logic [PW-1:0] PRE_LAST = PW'(M - 1);

  logic [PW-1:0]  pre_q, pre_d;
  logic           tick;
  logic [N-1:0]   ev_set, ev_pol;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   pol_q, pol_d;
  logic [N-1:0]   ovr_q, ovr_d;
  logic [IDW-1:0] last_q, last_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] chan_q, chan_d;
  logic           rise_q, rise_d;
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic           load, do_gnt;

  // Free-running mod-M prescaler; tick on the last count.
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      debounce_chan #(.K(K)) u_chan (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .sw     (sw[gi]),
        .db     (db[gi]),
        .ev_set (ev_set[gi]),
        .ev_pol (ev_pol[gi])
      );
    end
  endgenerate

  // Round-robin search: first pending channel at or after last_grant+1.
  always_comb begin : p_arb
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!gnt_found && pend_q[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  // Pending/overrun bookkeeping and output slot reload.
  always_comb begin
    load    = !valid_q || ev_ready;
    do_gnt  = load && gnt_found;
    pend_d  = pend_q;
    pol_d   = pol_q;
    ovr_d   = ovr_clr ? '0 : ovr_q;
    valid_d = valid_q;
    chan_d  = chan_q;
    rise_d  = rise_q;
    last_d  = last_q;

    if (do_gnt) pend_d[gnt_idx] = 1'b0;

    // A new event re-arms pend after a same-cycle grant; only an event that
    // lands on an un-granted pending entry counts as an overrun.
    for (int i = 0; i < N; i++) begin
      if (ev_set[i]) begin
        pend_d[i] = 1'b1;
        pol_d[i]  = ev_pol[i];
        if (pend_q[i] && !(do_gnt && gnt_idx == IDW'(i))) ovr_d[i] = 1'b1;
      end
    end

    if (load) begin
      valid_d = gnt_found;
      if (gnt_found) begin
        chan_d = gnt_idx;
        rise_d = pol_q[gnt_idx];
        last_d = gnt_idx;
      end
    end
  end

  // Top-level state registers; reset drops any queued or presented event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      pend_q  <= '0;
      pol_q   <= '0;
      ovr_q   <= '0;
      last_q  <= IDW'(N - 1);
      valid_q <= 1'b0;
      chan_q  <= '0;
      rise_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      pend_q  <= pend_d;
      pol_q   <= pol_d;
      ovr_q   <= ovr_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      rise_q  <= rise_d;
    end
  end

  assign ev_valid = valid_q;
  assign ev_chan  = chan_q;
  assign ev_rise  = rise_q;
  assign ovr      = ovr_q;
endmodule

// File: tb/tb_debounce_event_scheduler.sv
// Directed bench for debounce_event_scheduler (N=4, M=4, K=3) with an
// event scoreboard drained on every handshake.
module tb_debounce_event_scheduler;
  localparam int N = 4;
  localparam int M = 4;
  localparam int K = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic [3:0] db;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_chan;
  logic       ev_rise;
  logic [3:0] ovr;
  logic       ovr_clr;

  typedef struct packed {
    logic [1:0] chan;
    logic       rise;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  tests = 0;
  int  fails = 0;

  debounce_event_scheduler #(.N(N), .M(M), .K(K)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db       (db),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_chan  (ev_chan),
    .ev_rise  (ev_rise),
    .ovr      (ovr),
    .ovr_clr  (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk(input int c, input bit r);
    ev_t e;
    e.chan = 2'(c);
    e.rise = r;
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) until the masked db bits equal want; check the latency window.
  task automatic wait_db(input logic [3:0] mask, input logic [3:0] want,
                         input int lo, input int hi, input string tag);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (n < 40 && !hit) begin
      step(1);
      n++;
      if ((db & mask) === (want & mask)) hit = 1'b1;
    end
    check({tag, "_seen"}, 32'(hit), 32'd1);
    tests++;
    assert (n >= lo && n <= hi) else begin
      fails++;
      $error("FAIL %s_latency: observed %0d cycles expected %0d..%0d", tag, n, lo, hi);
    end
  endtask

  // Scoreboard: every accepted event must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_unexpected: observed chan %0d rise %0d expected no event", ev_chan, ev_rise);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("sb_chan", 32'(ev_chan), 32'(mon_e.chan));
        check("sb_rise", 32'(ev_rise), 32'(mon_e.rise));
      end
    end
  end

  initial begin
    bit flag_v, flag_db, unstable;

    // 1: reset values, then idle inputs produce nothing
    reset    = 1'b1;
    sw       = 4'b0000;
    ev_ready = 1'b1;
    ovr_clr  = 1'b0;
    step(3);
    check("rst_db",    32'(db),       32'h0);
    check("rst_valid", 32'(ev_valid), 32'h0);
    check("rst_chan",  32'(ev_chan),  32'h0);
    check("rst_rise",  32'(ev_rise),  32'h0);
    check("rst_ovr",   32'(ovr),      32'h0);
    reset  = 1'b0;
    flag_v = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step(1);
      if (ev_valid !== 1'b0) flag_v = 1'b1;
    end
    check("t1_no_valid", 32'(flag_v), 32'h0);
    check("t1_db",       32'(db),     32'h0);
    check("t1_ovr",      32'(ovr),    32'h0);

    // 2: single channel rise then fall
    sb.push_back(mk(0, 1'b1));
    sw[0] = 1'b1;
    wait_db(4'b0001, 4'b0001, 9, 13, "t2_rise");
    step(1);
    check("t2_valid", 32'(ev_valid), 32'h1);
    check("t2_chan",  32'(ev_chan),  32'h0);
    check("t2_rise",  32'(ev_rise),  32'h1);
    step(3);
    check("t2_drained", 32'(sb.size()), 32'h0);
    check("t2_idle",    32'(ev_valid),  32'h0);
    sb.push_back(mk(0, 1'b0));
    sw[0] = 1'b0;
    wait_db(4'b0001, 4'b0000, 9, 13, "t2_fall");
    step(3);
    check("t2_fall_drained", 32'(sb.size()), 32'h0);

    // 3: bouncing input is rejected, settled level accepted
    flag_v  = 1'b0;
    flag_db = 1'b0;
    for (int c = 0; c < 42; c++) begin
      if (c % 3 == 0) sw[1] = ~sw[1];
      step(1);
      if (db[1] !== 1'b0) flag_db = 1'b1;
      if (ev_valid !== 1'b0) flag_v = 1'b1;
    end
    check("t3_bounce_db",    32'(flag_db), 32'h0);
    check("t3_bounce_event", 32'(flag_v),  32'h0);
    sb.push_back(mk(1, 1'b1));
    sw[1] = 1'b1;
    wait_db(4'b0010, 4'b0010, 1, 13, "t3_settle");
    step(3);
    check("t3_drained", 32'(sb.size()), 32'h0);

    // 4: simultaneous rises, stalled consumer, then back-to-back drain
    sw    = 4'b0000;
    reset = 1'b1;
    step(2);
    reset    = 1'b0;
    ev_ready = 1'b0;
    sw       = 4'b1111;
    for (int c = 0; c < 4; c++) sb.push_back(mk(c, 1'b1));
    wait_db(4'b1111, 4'b1111, 9, 13, "t4_rise");
    step(1);
    check("t4_valid", 32'(ev_valid), 32'h1);
    check("t4_chan0", 32'(ev_chan),  32'h0);
    unstable = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step(1);
      if (ev_valid !== 1'b1 || ev_chan !== 2'd0 || ev_rise !== 1'b1) unstable = 1'b1;
    end
    check("t4_hold", 32'(unstable), 32'h0);
    ev_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("t4_seq_valid", 32'(ev_valid), 32'h1);
      check("t4_seq_chan",  32'(ev_chan),  32'(c));
      step(1);
    end
    check("t4_empty",   32'(ev_valid),  32'h0);
    check("t4_drained", 32'(sb.size()), 32'h0);

    // 5: overrun on channel 2 while the slot is stalled
    ev_ready = 1'b0;
    sw       = 4'b1011;
    sb.push_back(mk(2, 1'b0));
    wait_db(4'b0100, 4'b0000, 9, 13, "t5_fall1");
    sw = 4'b1111;
    wait_db(4'b0100, 4'b0100, 9, 13, "t5_rise");
    check("t5_no_ovr_yet", 32'(ovr), 32'h0);
    sw = 4'b1011;
    sb.push_back(mk(2, 1'b0));
    wait_db(4'b0100, 4'b0000, 9, 13, "t5_fall2");
    check("t5_ovr",       32'(ovr),      32'h4);
    check("t5_slot_chan", 32'(ev_chan),  32'h2);
    check("t5_slot_rise", 32'(ev_rise),  32'h0);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    check("t5_ovr_clr", 32'(ovr), 32'h0);
    ev_ready = 1'b1;
    step(4);
    check("t5_drained", 32'(sb.size()), 32'h0);
    check("t5_idle",    32'(ev_valid),  32'h0);

    // 6: reset with events queued and channels qualifying
    ev_ready = 1'b0;
    sw       = 4'b0000;
    wait_db(4'b1111, 4'b0000, 1, 13, "t6_fall");
    step(1);
    check("t6_pre_valid", 32'(ev_valid), 32'h1);
    sw = 4'b1111;
    step(2);
    reset = 1'b1;
    #1;
    check("t6_rst_db",    32'(db),       32'h0);
    check("t6_rst_valid", 32'(ev_valid), 32'h0);
    check("t6_rst_chan",  32'(ev_chan),  32'h0);
    check("t6_rst_rise",  32'(ev_rise),  32'h0);
    check("t6_rst_ovr",   32'(ovr),      32'h0);
    sw = 4'b0000;
    step(2);
    reset    = 1'b0;
    ev_ready = 1'b1;
    flag_v   = 1'b0;
    flag_db  = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step(1);
      if (ev_valid !== 1'b0) flag_v = 1'b1;
      if (db !== 4'b0000) flag_db = 1'b1;
    end
    check("t6_no_stale", 32'(flag_v),   32'h0);
    check("t6_db_zero",  32'(flag_db),  32'h0);
    check("sb_final",    32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
